// File: rtl/div_sched.sv
// Dual-rate tick scheduler: fast/slow strobes with reprogrammable periods applied on a slow-period boundary.
// Optional request checking (slow_max must not be below fast_max) is enabled by defining DIV_SCHED_CFG_CHECK_EN.
module div_sched #(
    parameter logic [31:0] FAST_MAX_INIT = 32'd9,
    parameter logic [31:0] SLOW_MAX_INIT = 32'd499999
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cfg_valid,
    input  logic [31:0] cfg_fast_max,
    input  logic [31:0] cfg_slow_max,
    output logic        cfg_ready,
    output logic        cfg_err,
    output logic        pending,
    output logic        clk_fast,
    output logic        clk_slow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_fast_q, cnt_fast_d;
    logic [31:0] cnt_slow_q, cnt_slow_d;
    logic [31:0] fast_max_q, fast_max_d;
    logic [31:0] slow_max_q, slow_max_d;
    logic [31:0] sh_fast_q, sh_fast_d;
    logic [31:0] sh_slow_q, sh_slow_d;
    logic        clk_fast_q, clk_fast_d;
    logic        clk_slow_q, clk_slow_d;
    logic        cfg_err_q, cfg_err_d;
    logic        accept, cfg_ok, running, fast_wrap, slow_wrap;

`ifdef DIV_SCHED_CFG_CHECK_EN
    assign cfg_ok = (cfg_slow_max >= cfg_fast_max);
`else
    assign cfg_ok = 1'b1;
`endif

    assign accept    = cfg_valid && (state_q != S_PEND);
    assign running   = enable && (state_q != S_IDLE);
    assign fast_wrap = (cnt_fast_q == fast_max_q);
    assign slow_wrap = (cnt_slow_q == slow_max_q);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_fast_q <= 32'd0;
            cnt_slow_q <= 32'd0;
            fast_max_q <= FAST_MAX_INIT;
            slow_max_q <= SLOW_MAX_INIT;
            sh_fast_q  <= 32'd0;
            sh_slow_q  <= 32'd0;
            clk_fast_q <= 1'b0;
            clk_slow_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_fast_q <= cnt_fast_d;
            cnt_slow_q <= cnt_slow_d;
            fast_max_q <= fast_max_d;
            slow_max_q <= slow_max_d;
            sh_fast_q  <= sh_fast_d;
            sh_slow_q  <= sh_slow_d;
            clk_fast_q <= clk_fast_d;
            clk_slow_q <= clk_slow_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_RUN;
            S_RUN: begin
                if (!enable)
                    state_d = S_IDLE;
                else if (accept && cfg_ok)
                    state_d = S_PEND;
            end
            S_PEND: begin
                if (!enable)
                    state_d = S_IDLE;
                else if (slow_wrap)
                    state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_fast_d = 32'd0;
        cnt_slow_d = 32'd0;
        fast_max_d = fast_max_q;
        slow_max_d = slow_max_q;
        sh_fast_d  = sh_fast_q;
        sh_slow_d  = sh_slow_q;
        clk_fast_d = 1'b0;
        clk_slow_d = 1'b0;
        cfg_err_d  = accept && !cfg_ok;
        if (running) begin
            cnt_fast_d = fast_wrap ? 32'd0 : cnt_fast_q + 32'd1;
            cnt_slow_d = slow_wrap ? 32'd0 : cnt_slow_q + 32'd1;
            clk_fast_d = fast_wrap;
            clk_slow_d = slow_wrap;
            if (state_q == S_PEND && slow_wrap) begin
                // New periods take effect here with both phases realigned to zero.
                fast_max_d = sh_fast_q;
                slow_max_d = sh_slow_q;
                cnt_fast_d = 32'd0;
                clk_fast_d = 1'b1;
            end else if (state_q == S_RUN && accept && cfg_ok) begin
                sh_fast_d = cfg_fast_max;
                sh_slow_d = cfg_slow_max;
            end
        end else if (state_q == S_PEND) begin
            fast_max_d = sh_fast_q;
            slow_max_d = sh_slow_q;
        end else if (accept && cfg_ok) begin
            // Not counting (idle or just stopping): no boundary to wait for.
            fast_max_d = cfg_fast_max;
            slow_max_d = cfg_slow_max;
        end
    end

    always_comb begin
        cfg_ready = (state_q != S_PEND);
        pending   = (state_q == S_PEND);
        clk_fast  = clk_fast_q;
        clk_slow  = clk_slow_q;
        cfg_err   = cfg_err_q;
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter FAST_MAX_INIT, default 9, fast period minus one loaded at reset.
REQ-002 SHALL have parameter SLOW_MAX_INIT, default 499999, slow period minus one loaded at reset.
REQ-003 SHALL have port clk_in  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  run tick generation when high.
REQ-006 SHALL have port cfg_valid  input  1  new period request present.
REQ-007 SHALL have port cfg_fast_max  input  32  requested fast period minus one.
REQ-008 SHALL have port cfg_slow_max  input  32  requested slow period minus one.
REQ-009 SHALL have port cfg_ready  output  1  request can be accepted this cycle.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse, request rejected.
REQ-011 SHALL have port pending  output  1  accepted config waiting for slow boundary.
REQ-012 SHALL have port clk_fast  output  1  registered one-cycle fast tick strobe.
REQ-013 SHALL have port clk_slow  output  1  registered one-cycle slow tick strobe.

Function
REQ-014 SHALL implement FSM states IDLE (enable low), RUN (enable high, no pending), PEND (enable high, config held in shadow).
REQ-015 SHALL hold active fast_max/slow_max registers plus shadow registers, all 32 bit, unsigned compare.
REQ-016 In RUN/PEND each counter SHALL increment per cycle and wrap to 0 when equal to its active max; the edge that wraps SHALL set the matching strobe high for exactly that following cycle.
REQ-017 Strobe period SHALL be max+1 cycles; max=0 SHALL give a strobe every cycle.
REQ-018 cfg_ready SHALL be high in IDLE and RUN, low in PEND; a request is accepted on cfg_valid and cfg_ready both high.
REQ-019 Accept in IDLE SHALL load active registers at the accept edge; state stays IDLE.
REQ-020 Accept in RUN SHALL capture shadow, go to PEND, assert pending from the next cycle.
REQ-021 In PEND, at the edge where cnt_slow wraps, active SHALL load shadow, both counters SHALL clear to 0, clk_slow and clk_fast SHALL both pulse, state returns to RUN.
REQ-022 A request accepted on the same edge as a slow wrap SHALL not apply at that wrap; it waits for the next wrap.
REQ-023 enable falling in RUN or PEND SHALL go to IDLE; a pending shadow SHALL be loaded immediately; counters clear; strobes low.
REQ-024 In IDLE counters SHALL hold 0 and both strobes stay low.
REQ-025 enable rising SHALL start counting from 0; first clk_fast one cycle after fast_max+1 counted cycles, no strobe at start.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, counters 0, active = *_INIT, shadow 0, clk_fast=0, clk_slow=0, pending=0, cfg_err=0.
REQ-027 Reset during PEND SHALL discard the shadow config.

Configuration
REQ-028 Macro DIV_SCHED_CFG_CHECK_EN defined: request with cfg_slow_max < cfg_fast_max SHALL be accepted (handshake completes), not loaded, cfg_err pulses one cycle, state unchanged.
REQ-029 Macro DIV_SCHED_CFG_CHECK_EN undefined: every request loads; cfg_err SHALL be constant 0.

Verification
REQ-030 Reset, FAST_MAX_INIT=9, SLOW_MAX_INIT=99, enable=1 -> clk_fast every 10 cycles, clk_slow every 100, each one cycle wide.
REQ-031 In RUN send fast=4, slow=49 mid-period -> pending=1, cfg_ready=0 until next slow wrap; then strobes every 5/50 cycles, fast phase realigned.
REQ-032 Request accepted on slow-wrap edge -> old periods retained for one full slow period, new ones after next wrap.
REQ-033 enable low while pending -> IDLE next cycle, strobes 0, new periods used after enable rises.
REQ-034 CHECK_EN defined, request fast=20 slow=10 -> cfg_err one-cycle pulse, periods unchanged; undefined -> loads, cfg_err 0.
REQ-035 rst_n pulse mid-PEND, asynchronous to clk_in -> outputs 0 immediately, periods revert to 10/100.
